rob: RTL and testbench
======================

Name: rob

Overview:
- Reorder buffer: circular queue of in-flight instructions between dispatch and the register file.
- Allocates a tag to each dispatched instruction and captures results broadcast by the ALU and the LSB.
- Retires entries in program order, one per cycle, onto the RF commit port (ROB_flag/ROB_new_idx/ROB_rd/ROB_val).
- Raises roll on a branch mispredict at commit; roll flushes the machine.

Parameters:
- ROB_SIZE, 32, number of entries; must be a power of two.
- ROB_IDX_W, 5, tag width; equals log2(ROB_SIZE). Tags zero-extend to 32 bits as {27'b0, idx}.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- rdy  in  1  global ready; when low, state holds
- Dis_flag  in  1  allocate an entry this cycle
- Dis_rd  in  5  destination register (0 = none)
- Dis_is_br  in  1  entry is a conditional branch
- Dis_is_st  in  1  entry is a store
- Dis_pred  in  1  predicted taken
- Dis_ROB_idx  out  ROB_IDX_W  tag granted to the dispatch (equals tail, combinational)
- ROB_full  out  1  count==ROB_SIZE, or count==ROB_SIZE-1 while Dis_flag is high
- Q1_idx, Q2_idx  in  ROB_IDX_W  operand lookup tags from dispatch
- Q1_R, Q2_R  out  1  queried entry is ready (combinational)
- Q1_V, Q2_V  out  32  queried entry value
- ALU_flag  in  1  ALU result valid
- ALU_idx  in  ROB_IDX_W  ALU result tag
- ALU_val  in  32  ALU result value
- ALU_jump  in  1  actual branch outcome
- ALU_pc  in  32  correct next PC when mispredicted
- LSB_flag  in  1  LSB result valid
- LSB_idx  in  ROB_IDX_W  LSB result tag
- LSB_val  in  32  LSB result value
- ROB_flag  out  1  commit pulse to RF
- ROB_new_idx  out  ROB_IDX_W  committed tag
- ROB_rd  out  5  committed destination register
- ROB_val  out  32  committed value
- ROB_st_commit  out  1  head store retired; LSB may write memory
- roll  out  1  flush pulse
- roll_pc  out  32  fetch redirect target

Behaviour:
- Per-entry state: busy, ready, rd, val, is_br, is_st, pred, jump, npc. Plus head, tail, count.
- Reset: head=tail=count=0; all busy=0, ready=0. All registered outputs are 0: ROB_flag, ROB_new_idx, ROB_rd, ROB_val, ROB_st_commit, roll, roll_pc.
- rdy low: no state change. Registered outputs hold their values. No allocation or commit occurs.
- Allocate:
  - Condition: Dis_flag && !ROB_full.
  - Entry[tail] gets busy=1, ready=0, and the dispatch fields.
  - tail increments modulo ROB_SIZE (wraps 31 to 0).
- Writeback:
  - ALU_flag sets entry[ALU_idx] ready=1 and stores val, jump, npc.
  - LSB_flag sets entry[LSB_idx] ready=1 and stores val.
  - Both may occur in the same cycle on distinct tags.
  - Writeback and allocation to the same index in one cycle cannot occur; this is not checked.
- Operand query:
  - Q*_R=1 when entry[Q*_idx] is ready.
  - It is also 1 when ALU_flag or LSB_flag targets Q*_idx this cycle; that writeback's value is forwarded to Q*_V.
  - Otherwise Q*_R=0 and Q*_V=0.
- Commit:
  - Condition: count>0 && entry[head].busy && ready.
  - Next cycle, ROB_flag=1 with ROB_new_idx=head and ROB_rd=rd.
  - ROB_rd is forced to 0 for branches and stores.
  - ROB_val=val. ROB_st_commit=is_st.
  - Entry busy clears; head increments modulo ROB_SIZE.
  - Only one commit per cycle. Every commit pulse lasts exactly one cycle.
- Mispredict: the committing entry has is_br && jump!=pred.
  - Next cycle, roll=1 and roll_pc=npc, alongside that entry's ROB_flag pulse.
  - In the same edge: head=tail=count=0 and all busy cleared.
  - An allocation in that cycle is discarded.
- roll input effect: the cycle roll is high, no allocate, writeback, or commit is accepted. roll self-clears after one cycle.
- Count rules:
  - Allocate and commit in the same cycle: count unchanged.
  - Full: no allocation; the dispatch must hold.
  - Empty: no commit; ROB_flag=0.
- Reset mid-operation overrides roll and everything else.

Test Plan:
- Reset, then dispatch 3 ALU ops with rd=1,2,3 → tags 0,1,2. Write back out of order (2,0,1) with vals 0x30,0x10,0x20 → ROB_flag pulses in order 0,1,2 with ROB_rd 1,2,3 and ROB_val 0x10,0x20,0x30.
- Dispatch 32 entries without writeback → ROB_full=1 at count=31 while Dis_flag is high, and at count=32. A 33rd Dis_flag leaves tail=0 and count=32.
- Fill to 32, commit 1, dispatch 1 → new tag is 0 (wrap-around). Count stays 32.
- Branch at tag 4 with pred=0; ALU writes jump=1, pc=0x1000 → at commit: roll=1, roll_pc=0x1000, ROB_rd=0. Next cycle count=0 and Dis_ROB_idx=0.
- Query Q1_idx=5 while ALU_flag writes idx 5 val 0xDEAD → Q1_R=1 and Q1_V=0xDEAD in the same cycle.
- Hold rdy=0 for 3 cycles with a ready head → no ROB_flag pulse and head unchanged. After rdy=1, the commit occurs next cycle.

Source files
------------

// File: rtl/rob.sv
// Reorder buffer: circular queue of in-flight instructions that captures ALU/LSB
// results, retires them in program order and flushes on a mispredicted branch.
module rob #(
  parameter int ROB_SIZE  = 32,
  parameter int ROB_IDX_W = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rdy,
  input  logic                 Dis_flag,
  input  logic [4:0]           Dis_rd,
  input  logic                 Dis_is_br,
  input  logic                 Dis_is_st,
  input  logic                 Dis_pred,
  output logic [ROB_IDX_W-1:0] Dis_ROB_idx,
  output logic                 ROB_full,
  input  logic [ROB_IDX_W-1:0] Q1_idx,
  input  logic [ROB_IDX_W-1:0] Q2_idx,
  output logic                 Q1_R,
  output logic                 Q2_R,
  output logic [31:0]          Q1_V,
  output logic [31:0]          Q2_V,
  input  logic                 ALU_flag,
  input  logic [ROB_IDX_W-1:0] ALU_idx,
  input  logic [31:0]          ALU_val,
  input  logic                 ALU_jump,
  input  logic [31:0]          ALU_pc,
  input  logic                 LSB_flag,
  input  logic [ROB_IDX_W-1:0] LSB_idx,
  input  logic [31:0]          LSB_val,
  output logic                 ROB_flag,
  output logic [ROB_IDX_W-1:0] ROB_new_idx,
  output logic [4:0]           ROB_rd,
  output logic [31:0]          ROB_val,
  output logic                 ROB_st_commit,
  output logic                 roll,
  output logic [31:0]          roll_pc
);

  localparam logic [ROB_IDX_W:0] FULL_CNT = (ROB_IDX_W+1)'(ROB_SIZE);
  localparam logic [ROB_IDX_W:0] LAST_CNT = (ROB_IDX_W+1)'(ROB_SIZE - 1);

  logic [ROB_SIZE-1:0]  busy, ready, is_br, is_st, pred, jump;
  logic [4:0]           rd_q  [ROB_SIZE];
  logic [31:0]          val_q [ROB_SIZE];
  logic [31:0]          npc_q [ROB_SIZE];
  logic [ROB_IDX_W-1:0] head, tail;
  logic [ROB_IDX_W:0]   count;

  logic accept, alloc_en, alu_en, lsb_en, commit_en, mispredict;

  // ROB_full looks one dispatch ahead so the front end stalls before the slot
  // it is filling right now turns out to be the last one.
  assign ROB_full    = (count == FULL_CNT) || ((count == LAST_CNT) && Dis_flag);
  assign Dis_ROB_idx = tail;

  assign accept     = rdy && !roll;
  assign alloc_en   = accept && Dis_flag && (count != FULL_CNT);
  assign alu_en     = accept && ALU_flag;
  assign lsb_en     = accept && LSB_flag;
  assign commit_en  = accept && (count != '0) && busy[head] && ready[head];
  assign mispredict = commit_en && is_br[head] && (jump[head] != pred[head]);

  always_comb begin
    Q1_R = 1'b0;
    Q1_V = '0;
    Q2_R = 1'b0;
    Q2_V = '0;
    if (ALU_flag && (ALU_idx == Q1_idx)) begin
      Q1_R = 1'b1;
      Q1_V = ALU_val;
    end else if (LSB_flag && (LSB_idx == Q1_idx)) begin
      Q1_R = 1'b1;
      Q1_V = LSB_val;
    end else if (ready[Q1_idx]) begin
      Q1_R = 1'b1;
      Q1_V = val_q[Q1_idx];
    end
    if (ALU_flag && (ALU_idx == Q2_idx)) begin
      Q2_R = 1'b1;
      Q2_V = ALU_val;
    end else if (LSB_flag && (LSB_idx == Q2_idx)) begin
      Q2_R = 1'b1;
      Q2_V = LSB_val;
    end else if (ready[Q2_idx]) begin
      Q2_R = 1'b1;
      Q2_V = val_q[Q2_idx];
    end
  end

  // Payload storage needs no reset: busy/ready gate every use of it.
  always_ff @(posedge clk) begin
    if (alloc_en) begin
      rd_q[tail]  <= Dis_rd;
      is_br[tail] <= Dis_is_br;
      is_st[tail] <= Dis_is_st;
      pred[tail]  <= Dis_pred;
    end
    if (alu_en) begin
      val_q[ALU_idx] <= ALU_val;
      jump[ALU_idx]  <= ALU_jump;
      npc_q[ALU_idx] <= ALU_pc;
    end
    if (lsb_en) begin
      val_q[LSB_idx] <= LSB_val;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head          <= '0;
      tail          <= '0;
      count         <= '0;
      busy          <= '0;
      ready         <= '0;
      ROB_flag      <= 1'b0;
      ROB_new_idx   <= '0;
      ROB_rd        <= '0;
      ROB_val       <= '0;
      ROB_st_commit <= 1'b0;
      roll          <= 1'b0;
      roll_pc       <= '0;
    end else begin
      if (rdy) begin
        ROB_flag      <= 1'b0;
        ROB_st_commit <= 1'b0;
        roll          <= 1'b0;
      end
      if (alloc_en) begin
        busy[tail]  <= 1'b1;
        ready[tail] <= 1'b0;
      end
      if (alu_en) ready[ALU_idx] <= 1'b1;
      if (lsb_en) ready[LSB_idx] <= 1'b1;
      if (commit_en) begin
        ROB_flag      <= 1'b1;
        ROB_new_idx   <= head;
        ROB_rd        <= (is_br[head] || is_st[head]) ? 5'd0 : rd_q[head];
        ROB_val       <= val_q[head];
        ROB_st_commit <= is_st[head];
        busy[head]    <= 1'b0;
      end
      // A mispredict empties the queue; it overrides this cycle's allocation.
      if (mispredict) begin
        roll    <= 1'b1;
        roll_pc <= npc_q[head];
        head    <= '0;
        tail    <= '0;
        count   <= '0;
        busy    <= '0;
        ready   <= '0;
      end else begin
        if (alloc_en)  tail <= tail + ROB_IDX_W'(1);
        if (commit_en) head <= head + ROB_IDX_W'(1);
        count <= count + (ROB_IDX_W+1)'(alloc_en) - (ROB_IDX_W+1)'(commit_en);
      end
    end
  end

endmodule

// File: tb/tb_rob.sv
// Self-checking bench for rob: a scoreboard of dispatched tags in program order
// plus a small per-tag model predicts every commit, roll and full/tag response.
module tb_rob;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rdy = 1'b1;
  logic        Dis_flag = 1'b0, Dis_is_br = 1'b0, Dis_is_st = 1'b0, Dis_pred = 1'b0;
  logic [4:0]  Dis_rd = '0;
  logic [4:0]  Dis_ROB_idx;
  logic        ROB_full;
  logic [4:0]  Q1_idx = '0, Q2_idx = '0;
  logic        Q1_R, Q2_R;
  logic [31:0] Q1_V, Q2_V;
  logic        ALU_flag = 1'b0, ALU_jump = 1'b0;
  logic [4:0]  ALU_idx = '0;
  logic [31:0] ALU_val = '0, ALU_pc = '0;
  logic        LSB_flag = 1'b0;
  logic [4:0]  LSB_idx = '0;
  logic [31:0] LSB_val = '0;
  logic        ROB_flag, ROB_st_commit, roll;
  logic [4:0]  ROB_new_idx, ROB_rd;
  logic [31:0] ROB_val, roll_pc;

  always #5 clk = ~clk;

  rob #(.ROB_SIZE(32), .ROB_IDX_W(5)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .Dis_flag(Dis_flag), .Dis_rd(Dis_rd), .Dis_is_br(Dis_is_br),
    .Dis_is_st(Dis_is_st), .Dis_pred(Dis_pred),
    .Dis_ROB_idx(Dis_ROB_idx), .ROB_full(ROB_full),
    .Q1_idx(Q1_idx), .Q2_idx(Q2_idx), .Q1_R(Q1_R), .Q2_R(Q2_R),
    .Q1_V(Q1_V), .Q2_V(Q2_V),
    .ALU_flag(ALU_flag), .ALU_idx(ALU_idx), .ALU_val(ALU_val),
    .ALU_jump(ALU_jump), .ALU_pc(ALU_pc),
    .LSB_flag(LSB_flag), .LSB_idx(LSB_idx), .LSB_val(LSB_val),
    .ROB_flag(ROB_flag), .ROB_new_idx(ROB_new_idx), .ROB_rd(ROB_rd),
    .ROB_val(ROB_val), .ROB_st_commit(ROB_st_commit),
    .roll(roll), .roll_pc(roll_pc)
  );

  int          checks = 0;
  int          errors = 0;
  logic [4:0]  sb_q[$];
  logic [4:0]  m_rd   [32];
  logic [31:0] m_val  [32];
  logic [31:0] m_npc  [32];
  logic        m_br   [32];
  logic        m_st   [32];
  logic        m_pred [32];
  logic        m_jump [32];
  int          exp_count = 0;
  logic [4:0]  exp_tail = '0;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Commit outputs are registered, so they are judged just after each edge.
  task automatic monitorCommit();
    logic [4:0] t;
    logic       mis;
    if (ROB_flag === 1'b1) begin
      if (sb_q.size() == 0) begin
        checkOutput("unexpected_commit", 32'(ROB_flag), 32'd0);
      end else begin
        t   = sb_q.pop_front();
        mis = m_br[t] && (m_jump[t] != m_pred[t]);
        checkOutput("commit_idx", 32'(ROB_new_idx), 32'(t));
        checkOutput("commit_rd", 32'(ROB_rd), (m_br[t] || m_st[t]) ? 32'd0 : 32'(m_rd[t]));
        checkOutput("commit_val", ROB_val, m_val[t]);
        checkOutput("commit_st", 32'(ROB_st_commit), 32'(m_st[t]));
        checkOutput("commit_roll", 32'(roll), 32'(mis));
        if (mis) begin
          checkOutput("roll_pc", roll_pc, m_npc[t]);
          sb_q.delete();
          exp_count = 0;
          exp_tail  = '0;
        end else begin
          exp_count--;
        end
      end
    end else begin
      checkOutput("idle_roll", 32'(roll), 32'd0);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    monitorCommit();
  endtask

  task automatic setInputs(input logic dis, input logic [4:0] rd, input logic br,
                           input logic st, input logic pr,
                           input logic alu, input logic [4:0] aidx, input logic [31:0] aval,
                           input logic ajump, input logic [31:0] apc,
                           input logic lsb, input logic [4:0] lidx, input logic [31:0] lval);
    Dis_flag = dis; Dis_rd = rd; Dis_is_br = br; Dis_is_st = st; Dis_pred = pr;
    ALU_flag = alu; ALU_idx = aidx; ALU_val = aval; ALU_jump = ajump; ALU_pc = apc;
    LSB_flag = lsb; LSB_idx = lidx; LSB_val = lval;
    #1;
    checkOutput("full", 32'(ROB_full), 32'((exp_count == 32) || ((exp_count == 31) && dis)));
    if (dis) begin
      checkOutput("dis_tag", 32'(Dis_ROB_idx), 32'(exp_tail));
      if (exp_count < 32) begin
        sb_q.push_back(exp_tail);
        m_rd[exp_tail] = rd; m_br[exp_tail] = br; m_st[exp_tail] = st; m_pred[exp_tail] = pr;
        exp_tail = exp_tail + 5'd1;
        exp_count++;
      end
    end
    if (alu) begin
      m_val[aidx] = aval; m_jump[aidx] = ajump; m_npc[aidx] = apc;
    end
    if (lsb) m_val[lidx] = lval;
  endtask

  task automatic applyStimulus(input logic dis, input logic [4:0] rd, input logic br,
                               input logic st, input logic pr,
                               input logic alu, input logic [4:0] aidx, input logic [31:0] aval,
                               input logic ajump, input logic [31:0] apc,
                               input logic lsb, input logic [4:0] lidx, input logic [31:0] lval);
    setInputs(dis, rd, br, st, pr, alu, aidx, aval, ajump, apc, lsb, lidx, lval);
    tick();
  endtask

  task automatic dispatchOp(input logic [4:0] rd, input logic br, input logic st, input logic pr);
    applyStimulus(1'b1, rd, br, st, pr, 1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 1'b0, 5'd0, 32'd0);
  endtask

  task automatic aluWb(input logic [4:0] idx, input logic [31:0] v, input logic j, input logic [31:0] pc);
    applyStimulus(1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, idx, v, j, pc, 1'b0, 5'd0, 32'd0);
  endtask

  task automatic lsbWb(input logic [4:0] idx, input logic [31:0] v);
    applyStimulus(1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 1'b1, idx, v);
  endtask

  task automatic idle();
    applyStimulus(1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 1'b0, 5'd0, 32'd0);
  endtask

  task automatic drain();
    int n = 0;
    while (sb_q.size() != 0 && n < 40) begin
      idle();
      n++;
    end
    checkOutput("drain_empty", 32'(sb_q.size()), 32'd0);
  endtask

  task automatic doReset();
    rst = 1'b1; rdy = 1'b1;
    Dis_flag = 1'b0; ALU_flag = 1'b0; LSB_flag = 1'b0; Q1_idx = '0; Q2_idx = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_flag", 32'(ROB_flag), 32'd0);
    checkOutput("rst_new_idx", 32'(ROB_new_idx), 32'd0);
    checkOutput("rst_rd", 32'(ROB_rd), 32'd0);
    checkOutput("rst_val", ROB_val, 32'd0);
    checkOutput("rst_st", 32'(ROB_st_commit), 32'd0);
    checkOutput("rst_roll", 32'(roll), 32'd0);
    checkOutput("rst_roll_pc", roll_pc, 32'd0);
    checkOutput("rst_tag", 32'(Dis_ROB_idx), 32'd0);
    checkOutput("rst_full", 32'(ROB_full), 32'd0);
    checkOutput("rst_q1r", 32'(Q1_R), 32'd0);
    rst = 1'b0;
    sb_q.delete();
    exp_count = 0;
    exp_tail  = '0;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "[TB] simulation time limit exceeded");
  end

  initial begin
    // In-order retirement of out-of-order writebacks, stores, dual writeback.
    doReset();
    dispatchOp(5'd1, 1'b0, 1'b0, 1'b0);
    dispatchOp(5'd2, 1'b0, 1'b0, 1'b0);
    dispatchOp(5'd3, 1'b0, 1'b0, 1'b0);
    aluWb(5'd2, 32'h30, 1'b0, 32'd0);
    aluWb(5'd0, 32'h10, 1'b0, 32'd0);
    lsbWb(5'd1, 32'h20);
    drain();
    dispatchOp(5'd7, 1'b0, 1'b1, 1'b0);
    dispatchOp(5'd8, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd4, 32'h44, 1'b0, 32'd0,
                  1'b1, 5'd3, 32'h33);
    drain();

    // Fill, overflow attempt, then wrap-around allocation at full occupancy.
    doReset();
    for (int i = 0; i < 32; i++) dispatchOp(5'(i), 1'b0, 1'b0, 1'b0);
    idle();
    dispatchOp(5'd20, 1'b0, 1'b0, 1'b0);
    checkOutput("full_tail", 32'(Dis_ROB_idx), 32'(exp_tail));
    aluWb(5'd0, 32'h99, 1'b0, 32'd0);
    idle();
    dispatchOp(5'd21, 1'b0, 1'b0, 1'b0);
    idle();

    // Operand forwarding, a correct branch, then a mispredict flush.
    doReset();
    dispatchOp(5'd1, 1'b0, 1'b0, 1'b0);
    dispatchOp(5'd2, 1'b0, 1'b0, 1'b0);
    dispatchOp(5'd3, 1'b0, 1'b0, 1'b0);
    dispatchOp(5'd5, 1'b1, 1'b0, 1'b1);
    dispatchOp(5'd6, 1'b1, 1'b0, 1'b0);
    dispatchOp(5'd9, 1'b0, 1'b0, 1'b0);
    Q1_idx = 5'd5;
    setInputs(1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 1'b0, 5'd0, 32'd0);
    checkOutput("q1r_pending", 32'(Q1_R), 32'd0);
    checkOutput("q1v_pending", Q1_V, 32'd0);
    tick();
    setInputs(1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd5, 32'hDEAD, 1'b0, 32'd0, 1'b0, 5'd0, 32'd0);
    checkOutput("q1r_fwd", 32'(Q1_R), 32'd1);
    checkOutput("q1v_fwd", Q1_V, 32'hDEAD);
    tick();
    Q2_idx = 5'd0;
    setInputs(1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 1'b1, 5'd0, 32'h10);
    checkOutput("q1r_entry", 32'(Q1_R), 32'd1);
    checkOutput("q1v_entry", Q1_V, 32'hDEAD);
    checkOutput("q2r_fwd", 32'(Q2_R), 32'd1);
    checkOutput("q2v_fwd", Q2_V, 32'h10);
    tick();
    aluWb(5'd1, 32'h20, 1'b0, 32'd0);
    aluWb(5'd2, 32'h30, 1'b0, 32'd0);
    aluWb(5'd3, 32'h33, 1'b1, 32'h2000);
    aluWb(5'd4, 32'h44, 1'b1, 32'h1000);
    idle();
    checkOutput("roll_tag", 32'(Dis_ROB_idx), 32'd0);
    idle();
    dispatchOp(5'd10, 1'b0, 1'b0, 1'b0);
    aluWb(5'd0, 32'h77, 1'b0, 32'd0);
    drain();

    // Global stall with a ready head: nothing moves until rdy returns.
    doReset();
    dispatchOp(5'd4, 1'b0, 1'b0, 1'b0);
    aluWb(5'd0, 32'h55, 1'b0, 32'd0);
    rdy = 1'b0; ALU_flag = 1'b0; LSB_flag = 1'b0; Dis_flag = 1'b1; Dis_rd = 5'd6;
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("hold_flag", 32'(ROB_flag), 32'd0);
      checkOutput("hold_tag", 32'(Dis_ROB_idx), 32'd1);
    end
    Dis_flag = 1'b0; rdy = 1'b1;
    tick();
    checkOutput("resume_flag", 32'(ROB_flag), 32'd1);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
